// File: rtl/bcd_conv_seq_if.sv
// Handshake bundle for the binary-to-BCD converter.
// Upstream value in, packed BCD result plus blank mask out.
interface bcd_conv_seq_if #(
    parameter int W      = 16,
    parameter int DIGITS = 5
);
    logic                  valid_i;
    logic [W-1:0]          data_i;
    logic                  ready_o;
    logic                  valid_o;
    logic                  ready_i;
    logic [4*DIGITS-1:0]   bcd_o;
    logic [DIGITS-1:0]     blank_o;
    logic                  busy_o;

    modport slave (
        input  valid_i,
        input  data_i,
        input  ready_i,
        output ready_o,
        output valid_o,
        output bcd_o,
        output blank_o,
        output busy_o
    );

    modport master (
        output valid_i,
        output data_i,
        output ready_i,
        input  ready_o,
        input  valid_o,
        input  bcd_o,
        input  blank_o,
        input  busy_o
    );
endinterface

// File: rtl/bcd_conv_seq.sv
// Sequential double-dabble binary to packed BCD, one bit per clock,
// with valid/ready on both sides and a leading-zero blank mask.
module bcd_conv_seq #(
    parameter int W      = 16,
    parameter int DIGITS = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    bcd_conv_seq_if.slave     io
);

    localparam int CW = $clog2(W + 1);
    localparam int BW = 4 * DIGITS;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [W-1:0]      bin_q, bin_d;
    logic [BW-1:0]     bcd_acc_q, bcd_acc_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [BW-1:0]     bcd_q, bcd_d;
    logic [DIGITS-1:0] blank_q, blank_d;
    logic              valid_q, valid_d;

    logic              ready;
    logic [BW-1:0]     adj;
    logic [BW+W-1:0]   shifted;
    logic [BW-1:0]     acc_next;
    logic [DIGITS-1:0] mask;
    logic              zero_hi;

    assign ready = (state_q == IDLE) & ~rst_i;

    // Add-3 correction: each nibble independently, no inter-nibble carry
    always_comb begin
        adj = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_acc_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = bcd_acc_q[4*i +: 4] + 4'd3;
            end else begin
                adj[4*i +: 4] = bcd_acc_q[4*i +: 4];
            end
        end
    end

    assign shifted  = {adj, bin_q} << 1;
    assign acc_next = shifted[BW+W-1:W];

    // Units digit is never blanked so zero still shows "0"
    always_comb begin
        mask    = '0;
        zero_hi = 1'b1;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            zero_hi = zero_hi & (acc_next[4*k +: 4] == 4'd0);
            mask[k] = zero_hi;
        end
    end

    always_comb begin
        state_d   = state_q;
        bin_d     = bin_q;
        bcd_acc_d = bcd_acc_q;
        cnt_d     = cnt_q;
        bcd_d     = bcd_q;
        blank_d   = blank_q;
        valid_d   = valid_q;

        unique case (state_q)
            IDLE: begin
                if (io.valid_i && ready) begin
                    bin_d     = io.data_i;
                    bcd_acc_d = '0;
                    cnt_d     = CW'(W);
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                bin_d     = shifted[W-1:0];
                bcd_acc_d = acc_next;
                cnt_d     = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    bcd_d   = acc_next;
                    blank_d = mask;
                    valid_d = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (io.ready_i) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            bin_q     <= '0;
            bcd_acc_q <= '0;
            cnt_q     <= '0;
            bcd_q     <= '0;
            blank_q   <= '0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            bin_q     <= bin_d;
            bcd_acc_q <= bcd_acc_d;
            cnt_q     <= cnt_d;
            bcd_q     <= bcd_d;
            blank_q   <= blank_d;
            valid_q   <= valid_d;
        end
    end

    assign io.ready_o = ready;
    assign io.busy_o  = (state_q == SHIFT);
    assign io.valid_o = valid_q;
    assign io.bcd_o   = bcd_q;
    assign io.blank_o = blank_q;

endmodule

// File: tb/tb_bcd_conv_seq.sv
// Directed bench for bcd_conv_seq with a result scoreboard
// fed at accept time and drained on each valid_o rise.
module tb_bcd_conv_seq;

    localparam int W = 16;
    localparam int D = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    bcd_conv_seq_if #(.W(W), .DIGITS(D)) bus ();

    bcd_conv_seq #(.W(W), .DIGITS(D)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .io    (bus)
    );

    typedef struct {
        logic [4*D-1:0] bcd;
        logic [D-1:0]   blank;
        int             acc;
    } exp_t;

    exp_t sbq[$];
    exp_t me;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   last_acc = 0;
    int   a0       = 0;
    logic vprev    = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [4*D-1:0] m_bcd(int v);
        int t;
        logic [4*D-1:0] r;
        t = v;
        r = '0;
        for (int i = 0; i < D; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic logic [D-1:0] m_blank(int v);
        logic [D-1:0] b;
        int p;
        b = '0;
        p = 1;
        for (int k = 1; k < D; k++) begin
            p = p * 10;
            b[k] = (v < p);
        end
        return b;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Result monitor: every valid_o rise must match the oldest accept
    always @(negedge clk) begin
        if (bus.valid_o && !vprev) begin
            if (sbq.size() == 0) begin
                chk("unexpected_result", 32'd1, 32'd0);
            end else begin
                me = sbq.pop_front();
                chk("bcd_o", 32'(bus.bcd_o), 32'(me.bcd));
                chk("blank_o", 32'(bus.blank_o), 32'(me.blank));
                chk("latency", 32'(cyc - me.acc), 32'(W));
            end
        end
        vprev <= bus.valid_o;
    end

    task automatic send(int v, bit keep);
        int n;
        n = 0;
        bus.data_i  = 16'(v);
        bus.valid_i = 1'b1;
        while (!bus.ready_o && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!bus.ready_o) begin
            chk("accept_timeout", 32'd0, 32'd1);
            bus.valid_i = 1'b0;
            return;
        end
        @(negedge clk);
        sbq.push_back('{bcd: m_bcd(v), blank: m_blank(v), acc: cyc});
        last_acc = cyc;
        if (!keep) bus.valid_i = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sbq.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", 32'(sbq.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bus.valid_i = 1'b0;
        bus.data_i  = '0;
        bus.ready_i = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_valid", 32'(bus.valid_o), 32'd0);
        chk("rst_bcd", 32'(bus.bcd_o), 32'd0);
        chk("rst_blank", 32'(bus.blank_o), 32'd0);
        chk("rst_busy", 32'(bus.busy_o), 32'd0);
        chk("rst_ready", 32'(bus.ready_o), 32'd0);
        rst = 1'b0;
        #1;
        chk("ready_after_rst", 32'(bus.ready_o), 32'd1);
        @(negedge clk);

        bus.ready_i = 1'b1;
        send(0, 1'b0);
        drain();
        chk("zero_blank_const", 32'(bus.blank_o), 32'h1E);
        send(16'h7FFF, 1'b0);
        drain();
        chk("max_up_const", 32'(bus.bcd_o), 32'h32767);
        send(305, 1'b0);
        drain();
        send(16'hFFFF, 1'b0);
        drain();
        chk("ffff_const", 32'(bus.bcd_o), 32'h65535);
        send(9, 1'b0);
        drain();

        // Back-pressure with upstream noise while the result waits
        bus.ready_i = 1'b0;
        send(4095, 1'b0);
        n = 0;
        while (!bus.valid_o && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("bp_rise", 32'(bus.valid_o), 32'd1);
        for (int i = 0; i < 10; i++) begin
            bus.valid_i = 1'($urandom_range(0, 1));
            bus.data_i  = 16'($urandom);
            @(negedge clk);
            chk("bp_valid", 32'(bus.valid_o), 32'd1);
            chk("bp_bcd", 32'(bus.bcd_o), 32'(m_bcd(4095)));
            chk("bp_ready", 32'(bus.ready_o), 32'd0);
        end
        bus.valid_i = 1'b0;
        bus.ready_i = 1'b1;
        @(negedge clk);
        chk("bp_release_valid", 32'(bus.valid_o), 32'd0);
        chk("bp_release_ready", 32'(bus.ready_o), 32'd1);
        chk("bp_hold_bcd", 32'(bus.bcd_o), 32'(m_bcd(4095)));
        repeat (3) @(negedge clk);
        chk("bp_no_accept", 32'(bus.busy_o), 32'd0);

        // Reset lands on the 7th shift edge of 1234
        send(1234, 1'b0);
        repeat (6) @(negedge clk);
        chk("mid_busy", 32'(bus.busy_o), 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_ready", 32'(bus.ready_o), 32'd0);
        @(negedge clk);
        chk("mid_valid", 32'(bus.valid_o), 32'd0);
        chk("mid_busy0", 32'(bus.busy_o), 32'd0);
        chk("mid_bcd", 32'(bus.bcd_o), 32'd0);
        chk("mid_blank", 32'(bus.blank_o), 32'd0);
        chk("mid_sb", 32'(sbq.size()), 32'd1);
        if (sbq.size() != 0) void'(sbq.pop_front());
        rst = 1'b0;
        @(negedge clk);
        send(4321, 1'b0);
        drain();
        chk("post_rst_const", 32'(bus.bcd_o), 32'h04321);

        // Back-to-back with valid_i held high
        send(100, 1'b1);
        a0 = last_acc;
        send(200, 1'b1);
        chk("b2b_space1", 32'(last_acc - a0), 32'(W + 2));
        a0 = last_acc;
        send(300, 1'b0);
        chk("b2b_space2", 32'(last_acc - a0), 32'(W + 2));
        drain();
        chk("b2b_last", 32'(bus.bcd_o), 32'h00300);
        repeat (4) @(negedge clk);
        chk("final_idle", 32'(bus.valid_o), 32'd0);
        chk("final_sb", 32'(sbq.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
